mcpu_alu_sequencer: RTL and testbench
=====================================

Name: mcpu_alu_sequencer

Overview:
- Issuing side of the MCPU ALU interface: accepts 16-bit instruction words, decodes them and reads operands from an internal 4-entry register file.
- Drives the ALU cmd/in1/in2 inputs, waits for the result to settle, then writes it back along with the carry flag.
- Sits between the instruction source and the combinational ALU. It is the control and datapath initiator for every ALU operation.

Parameters:
- WORD_SIZE, 16, data width of registers and ALU operands.
- CMD_SIZE, 3, ALU command width.
- EXEC_WAIT, 2, cycles ALU inputs are held stable before the result is sampled (min 1). Covers the ALU's internal settle delay.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  16  instruction word. [15:13] opcode, [12:11] rd, [10:9] rs1, [8:7] rs2, [7:0] imm8.
- alu_cmd  out  CMD_SIZE  command to ALU.
- alu_in1  out  WORD_SIZE  operand 1 to ALU.
- alu_in2  out  WORD_SIZE  operand 2 to ALU.
- alu_out  in  WORD_SIZE  ALU result.
- alu_cf  in  1  ALU carry/borrow.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse when an illegal opcode retires.
- cf_q  out  1  architectural carry flag.
- dbg_addr  in  2  register-file debug read address.
- dbg_data  out  WORD_SIZE  combinational read of reg[dbg_addr].

Behaviour:
- Reset (clk edge with reset=1) clears:
  - all 4 registers, cf_q, alu_cmd, alu_in1, alu_in2, done, err;
  - state goes to IDLE and instr_ready=1 on the following cycle.
- Reset mid-instruction aborts it: no writeback, no done or err pulse, cf_q cleared.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 NOT map 1:1 onto alu_cmd.
  - 6 LDI: rd <= zero-extended imm8. The ALU is not used.
  - 7 illegal.
- State machine:
  - IDLE: instr_ready=1. If instr_valid=1, latch instr and go to DECODE. instr is ignored when instr_ready=0.
  - DECODE:
    - ALU opcode: register alu_cmd, alu_in1=reg[rs1], alu_in2=reg[rs2], then go to EXECUTE.
    - LDI: write rd, pulse done next cycle, return to IDLE.
    - Illegal: pulse err and done, no register or cf_q change, return to IDLE.
  - EXECUTE: hold alu_cmd/in1/in2 constant for EXEC_WAIT cycles (down-counter), then go to WRITEBACK.
  - WRITEBACK:
    - reg[rd] <= alu_out.
    - cf_q <= alu_cf only for ADD/SUB. AND/OR/XOR/NOT leave cf_q unchanged.
    - done pulses; return to IDLE.
- ALU inputs stay at their last values outside EXECUTE; they are never X after reset.
- Latency, accept edge to done high:
  - ALU op: 3+EXEC_WAIT cycles (5 at default);
  - LDI and illegal: 2 cycles.
- Throughput: one instruction in flight. The next accept is possible on the cycle after done.
- Operand reads happen in DECODE, before writeback, so rd==rs1==rs2 is legal and uses the old value.
- dbg_data reflects a write on the cycle after the writeback edge.
- Widths: imm8 zero-extended to WORD_SIZE. Register addresses are 2 bits, so there is no out-of-range case.

Optional Feature:
- Macro: MCPU_SEQ_ZERO_FLAG_EN.
- Defined: adds output zf_q (1 bit), reset 0. Updated on every ALU writeback and LDI to (written value == 0). Unchanged on illegal opcodes.
- Undefined: no zf_q port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset, then LDI r1=0x00FF, LDI r2=0x0F0F, AND r3=r1&r2 -> dbg r3=0x000F; done 5 cycles after the AND accept; cf_q=0.
- LDI r1=0xFF, ADD r1=r1+r1 repeated 8 times -> r1=0xFF00, cf_q=0. Then ADD r2=r1+r1 -> r2=0xFE00, cf_q=1. Then XOR r3=r2^r2 -> r3=0, cf_q stays 1.
- SUB r0=r0-r1 with r0=0, r1=1 -> r0=0xFFFF, cf_q=1. Holding instr_valid high continuously -> exactly one accept per retire, instr_ready low from accept to done.
- Opcode 7 (instr=0xE000) -> err and done pulse together 2 cycles after accept; registers and cf_q unchanged.
- Assert reset during EXECUTE of ADD r3 -> r3 stays 0, no done pulse, cf_q=0, instr_ready=1 on the cycle after the reset edge.
- With MCPU_SEQ_ZERO_FLAG_EN defined: XOR r2=r1^r1 -> zf_q=1; then LDI r2=0x01 -> zf_q=0.

Source files
------------

// File: rtl/mcpu_alu_sequencer.sv
`default_nettype none
// ============================================================================
// mcpu_alu_sequencer : decode/issue/writeback sequencer for the MCPU ALU with a
// 4-entry register file. Option MCPU_SEQ_ZERO_FLAG_EN adds zf_q. Revision 1.0
// ============================================================================
module mcpu_alu_sequencer #(
   parameter int WORD_SIZE = 16,
   parameter int CMD_SIZE  = 3,
   parameter int EXEC_WAIT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [15:0]          instr,
   output logic [CMD_SIZE-1:0]  alu_cmd,
   output logic [WORD_SIZE-1:0] alu_in1,
   output logic [WORD_SIZE-1:0] alu_in2,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic                 alu_cf,
   output logic                 done,
   output logic                 err,
   output logic                 cf_q,
`ifdef MCPU_SEQ_ZERO_FLAG_EN
   output logic                 zf_q,
`endif
   input  logic [1:0]           dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);

   localparam int CNT_W = $clog2(EXEC_WAIT + 1);

   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_DECODE    = 2'd1;
   localparam logic [1:0] c_ST_EXECUTE   = 2'd2;
   localparam logic [1:0] c_ST_WRITEBACK = 2'd3;

   localparam logic [2:0] c_OP_ADD = 3'd3;
   localparam logic [2:0] c_OP_SUB = 3'd4;
   localparam logic [2:0] c_OP_LDI = 3'd6;
   localparam logic [2:0] c_OP_ILL = 3'd7;

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [15:0]          instr_q;
   logic [WORD_SIZE-1:0] regs_q [4];

   logic [2:0]           w_opcode;
   logic [1:0]           w_rd;
   logic [1:0]           w_rs1;
   logic [1:0]           w_rs2;
   logic [WORD_SIZE-1:0] w_imm;
   logic                 w_is_alu;
   logic                 w_sets_cf;

   assign w_opcode  = instr_q[15:13];
   assign w_rd      = instr_q[12:11];
   assign w_rs1     = instr_q[10:9];
   assign w_rs2     = instr_q[8:7];
   assign w_imm     = WORD_SIZE'(instr_q[7:0]);
   assign w_is_alu  = (w_opcode < c_OP_LDI);
   assign w_sets_cf = (w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB);

   assign instr_ready = (state_q == c_ST_IDLE);
   assign dbg_data    = regs_q[dbg_addr];

   // LDI and illegal opcodes pass through WRITEBACK only to time the done pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         c_ST_IDLE: begin
            if (instr_valid) state_d = c_ST_DECODE;
         end
         c_ST_DECODE: begin
            if (w_is_alu) begin
               state_d = c_ST_EXECUTE;
               cnt_d   = CNT_W'(EXEC_WAIT);
            end else begin
               state_d = c_ST_WRITEBACK;
            end
         end
         c_ST_EXECUTE: begin
            if (cnt_q == '0) state_d = c_ST_WRITEBACK;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         c_ST_WRITEBACK: state_d = c_ST_IDLE;
         default:        state_d = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_ST_IDLE;
         cnt_q   <= '0;
         instr_q <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
         cf_q    <= 1'b0;
         alu_cmd <= '0;
         alu_in1 <= '0;
         alu_in2 <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
`ifdef MCPU_SEQ_ZERO_FLAG_EN
         zf_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done    <= (state_q == c_ST_WRITEBACK);
         err     <= (state_q == c_ST_WRITEBACK) && (w_opcode == c_OP_ILL);

         if ((state_q == c_ST_IDLE) && instr_valid) instr_q <= instr;

         // Operands are captured here, so rd may alias rs1/rs2 safely.
         if (state_q == c_ST_DECODE) begin
            if (w_is_alu) begin
               alu_cmd <= CMD_SIZE'(w_opcode);
               alu_in1 <= regs_q[w_rs1];
               alu_in2 <= regs_q[w_rs2];
            end else if (w_opcode == c_OP_LDI) begin
               regs_q[w_rd] <= w_imm;
`ifdef MCPU_SEQ_ZERO_FLAG_EN
               zf_q         <= (w_imm == '0);
`endif
            end
         end

         if ((state_q == c_ST_WRITEBACK) && w_is_alu) begin
            regs_q[w_rd] <= alu_out;
            if (w_sets_cf) cf_q <= alu_cf;
`ifdef MCPU_SEQ_ZERO_FLAG_EN
            zf_q         <= (alu_out == '0);
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mcpu_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mcpu_alu_sequencer : self-checking bench with an ALU stand-in and a
// reference register-file model. Revision 1.0
// ============================================================================
module tb_mcpu_alu_sequencer;

   localparam int EXEC_WAIT = 2;
   localparam int LAT_ALU   = EXEC_WAIT + 3;
   localparam int LAT_SHORT = 2;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [2:0]  alu_cmd;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [15:0] alu_out;
   logic        alu_cf;
   logic        done;
   logic        err;
   logic        cf_q;
`ifdef MCPU_SEQ_ZERO_FLAG_EN
   logic        zf_q;
`endif
   logic [1:0]  dbg_addr;
   logic [15:0] dbg_data;

   mcpu_alu_sequencer #(
      .WORD_SIZE (16),
      .CMD_SIZE  (3),
      .EXEC_WAIT (EXEC_WAIT)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_cmd     (alu_cmd),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_out     (alu_out),
      .alu_cf      (alu_cf),
      .done        (done),
      .err         (err),
      .cf_q        (cf_q),
`ifdef MCPU_SEQ_ZERO_FLAG_EN
      .zf_q        (zf_q),
`endif
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in: result is corrupted until inputs have been stable EXEC_WAIT edges
   function automatic logic [16:0] alu_fn(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
      case (c)
         3'd0:    return {1'b0, a & b};
         3'd1:    return {1'b0, a | b};
         3'd2:    return {1'b0, a ^ b};
         3'd3:    return {1'b0, a} + {1'b0, b};
         3'd4:    return {1'b0, a} - {1'b0, b};
         3'd5:    return {1'b0, ~a};
         default: return 17'd0;
      endcase
   endfunction

   logic [34:0] alu_key_q;
   int          stable_q = 0;
   logic [16:0] alu_res;

   always @(posedge clk) begin
      if ({alu_cmd, alu_in1, alu_in2} !== alu_key_q) stable_q <= 0;
      else                                           stable_q <= stable_q + 1;
      alu_key_q <= {alu_cmd, alu_in1, alu_in2};
   end

   assign alu_res = alu_fn(alu_cmd, alu_in1, alu_in2);
   assign alu_out = (stable_q >= EXEC_WAIT) ? alu_res[15:0] : ~alu_res[15:0];
   assign alu_cf  = (stable_q >= EXEC_WAIT) ? alu_res[16]   : ~alu_res[16];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
      return {op, rd, rs1, rs2, 7'b0};
   endfunction

   function automatic logic [15:0] f_ldi(input logic [1:0] rd, input logic [7:0] imm);
      return {3'd6, rd, 3'b000, imm};
   endfunction

   // Reference model state
   logic [15:0] m_regs [4];
   logic        m_cf;
   logic        m_zf;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
      m_cf = 1'b0;
      m_zf = 1'b0;
   endtask

   task automatic model_exec(input logic [15:0] iw, output int lat, output logic e);
      logic [2:0]  op;
      logic [16:0] r;
      op = iw[15:13];
      e  = 1'b0;
      if (op == 3'd7) begin
         e   = 1'b1;
         lat = LAT_SHORT;
      end else if (op == 3'd6) begin
         m_regs[iw[12:11]] = {8'h00, iw[7:0]};
         m_zf = (iw[7:0] == 8'h00);
         lat  = LAT_SHORT;
      end else begin
         r = alu_fn(op, m_regs[iw[10:9]], m_regs[iw[8:7]]);
         m_regs[iw[12:11]] = r[15:0];
         if (op == 3'd3 || op == 3'd4) m_cf = r[16];
         m_zf = (r[15:0] == 16'h0);
         lat  = LAT_ALU;
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Issue one instruction; lat = edges from accept to done high (0 on timeout)
   task automatic issue(input logic [15:0] iw, output int lat, output logic e, output logic rbad);
      int n;
      lat  = 0;
      e    = 1'b0;
      rbad = 1'b0;
      n    = 0;
      while (!instr_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      instr       = iw;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            e   = err;
         end else if (instr_ready) begin
            rbad = 1'b1;
         end
      end
   endtask

   typedef struct {
      logic [15:0] instr;
      logic [1:0]  rd;
      logic [15:0] exp_val;
      logic        exp_cf;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   task automatic apply_vec(input vec_t v, input string tag);
      int   lat;
      logic e;
      logic rb;
      issue(v.instr, lat, e, rb);
      chk({tag, " latency"}, lat, v.exp_lat);
      chk({tag, " err"}, e, v.exp_err);
      chk({tag, " ready_low"}, rb, 1'b0);
      dbg_addr = v.rd;
      #1;
      chk({tag, " rd"}, dbg_data, v.exp_val);
      chk({tag, " cf"}, cf_q, v.exp_cf);
   endtask

   task automatic check_all_regs(input string tag);
      for (int r = 0; r < 4; r++) begin
         dbg_addr = 2'(r);
         #1;
         chk($sformatf("%s r%0d", tag, r), dbg_data, m_regs[r]);
      end
      chk({tag, " cf"}, cf_q, m_cf);
`ifdef MCPU_SEQ_ZERO_FLAG_EN
      chk({tag, " zf"}, zf_q, m_zf);
`endif
   endtask

   vec_t vecs[$];

   initial begin
      int          lat;
      int          exp_lat;
      logic        e;
      logic        exp_e;
      logic        rb;
      logic [15:0] iw;
      int          n_done;
      int          P;

      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0;
      dbg_addr    = 2'd0;

      // Vector table: r1=0x00FF, build r2=0x0F0F, then AND and friends
      vecs.push_back(vec_t'{f_ldi(2'd1, 8'hFF), 2'd1, 16'h00FF, 1'b0, LAT_SHORT, 1'b0});
      vecs.push_back(vec_t'{f_ldi(2'd2, 8'h0F), 2'd2, 16'h000F, 1'b0, LAT_SHORT, 1'b0});
      for (int k = 1; k <= 8; k++)
         vecs.push_back(vec_t'{f_alu(3'd3, 2'd2, 2'd2, 2'd2), 2'd2, 16'(16'h000F << k), 1'b0, LAT_ALU, 1'b0});
      vecs.push_back(vec_t'{f_ldi(2'd0, 8'h0F), 2'd0, 16'h000F, 1'b0, LAT_SHORT, 1'b0});
      vecs.push_back(vec_t'{f_alu(3'd1, 2'd2, 2'd2, 2'd0), 2'd2, 16'h0F0F, 1'b0, LAT_ALU, 1'b0});
      vecs.push_back(vec_t'{f_alu(3'd0, 2'd3, 2'd1, 2'd2), 2'd3, 16'h000F, 1'b0, LAT_ALU, 1'b0});
      vecs.push_back(vec_t'{16'hE000,                     2'd0, 16'h000F, 1'b0, LAT_SHORT, 1'b1});
      vecs.push_back(vec_t'{f_alu(3'd5, 2'd0, 2'd1, 2'd0), 2'd0, 16'hFF00, 1'b0, LAT_ALU, 1'b0});
      vecs.push_back(vec_t'{f_alu(3'd4, 2'd3, 2'd1, 2'd0), 2'd3, 16'h01FF, 1'b1, LAT_ALU, 1'b0});
      vecs.push_back(vec_t'{f_alu(3'd2, 2'd3, 2'd3, 2'd3), 2'd3, 16'h0000, 1'b1, LAT_ALU, 1'b0});
      vecs.push_back(vec_t'{f_ldi(2'd3, 8'h80), 2'd3, 16'h0080, 1'b1, LAT_SHORT, 1'b0});

      // Reset state
      do_reset();
      chk("reset ready", instr_ready, 1'b1);
      chk("reset done", done, 1'b0);
      chk("reset err", err, 1'b0);
      chk("reset alu_cmd", alu_cmd, 3'd0);
      chk("reset alu_in1", alu_in1, 16'h0);
      chk("reset alu_in2", alu_in2, 16'h0);
      check_all_regs("reset");

      foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Carry out of the top bit via repeated doubling
      do_reset();
      apply_vec(vec_t'{f_ldi(2'd1, 8'hFF), 2'd1, 16'h00FF, 1'b0, LAT_SHORT, 1'b0}, "dbl ldi");
      for (int k = 1; k <= 8; k++)
         apply_vec(vec_t'{f_alu(3'd3, 2'd1, 2'd1, 2'd1), 2'd1, 16'(16'h00FF << k), 1'b0, LAT_ALU, 1'b0},
                   $sformatf("dbl add%0d", k));
      apply_vec(vec_t'{f_alu(3'd3, 2'd2, 2'd1, 2'd1), 2'd2, 16'hFE00, 1'b1, LAT_ALU, 1'b0}, "dbl carry");
      apply_vec(vec_t'{f_alu(3'd2, 2'd3, 2'd2, 2'd2), 2'd3, 16'h0000, 1'b1, LAT_ALU, 1'b0}, "xor keeps cf");

      // instr_valid held high: one accept per retire
      do_reset();
      apply_vec(vec_t'{f_ldi(2'd1, 8'h01), 2'd1, 16'h0001, 1'b0, LAT_SHORT, 1'b0}, "held ldi");
      @(posedge clk); #1;
      P           = LAT_ALU + 1;
      dbg_addr    = 2'd0;
      instr       = f_alu(3'd4, 2'd0, 2'd0, 2'd1);
      instr_valid = 1'b1;
      for (int c = 0; c <= 3 * P; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         chk($sformatf("held c%0d ready", c), instr_ready, (c % P) == 0);
         chk($sformatf("held c%0d done", c), done, (c > 0) && ((c % P) == 0));
         if (c == P) begin
            chk("held first sub r0", dbg_data, 16'hFFFF);
            chk("held first sub cf", cf_q, 1'b1);
         end
      end
      instr_valid = 1'b0;
      chk("held final r0", dbg_data, 16'hFFFD);
      chk("held final cf", cf_q, 1'b0);

      // Reset during EXECUTE aborts the instruction
      do_reset();
      apply_vec(vec_t'{f_ldi(2'd1, 8'h05), 2'd1, 16'h0005, 1'b0, LAT_SHORT, 1'b0}, "abort ldi");
      apply_vec(vec_t'{f_alu(3'd4, 2'd2, 2'd0, 2'd1), 2'd2, 16'hFFFB, 1'b1, LAT_ALU, 1'b0}, "abort sub");
      instr       = f_alu(3'd3, 2'd3, 2'd1, 2'd1);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      chk("abort ready", instr_ready, 1'b1);
      chk("abort done", done, 1'b0);
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("abort no done", n_done, 0);
      check_all_regs("abort");

`ifdef MCPU_SEQ_ZERO_FLAG_EN
      do_reset();
      apply_vec(vec_t'{f_ldi(2'd1, 8'h5A), 2'd1, 16'h005A, 1'b0, LAT_SHORT, 1'b0}, "zf ldi");
      chk("zf after ldi", zf_q, 1'b0);
      apply_vec(vec_t'{f_alu(3'd2, 2'd2, 2'd1, 2'd1), 2'd2, 16'h0000, 1'b0, LAT_ALU, 1'b0}, "zf xor");
      chk("zf after xor", zf_q, 1'b1);
      apply_vec(vec_t'{16'hE000, 2'd0, 16'h0000, 1'b0, LAT_SHORT, 1'b1}, "zf illegal");
      chk("zf kept by illegal", zf_q, 1'b1);
      apply_vec(vec_t'{f_ldi(2'd2, 8'h01), 2'd2, 16'h0001, 1'b0, LAT_SHORT, 1'b0}, "zf ldi1");
      chk("zf after ldi1", zf_q, 1'b0);
`endif

      // Randomized instructions against the reference model
      do_reset();
      for (int t = 0; t < 150; t++) begin
         iw = 16'($urandom);
         if ((t % 4) == 0) iw[15:13] = 3'd6;
         model_exec(iw, exp_lat, exp_e);
         issue(iw, lat, e, rb);
         chk($sformatf("rand%0d latency", t), lat, exp_lat);
         chk($sformatf("rand%0d err", t), e, exp_e);
         check_all_regs($sformatf("rand%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
